// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the register-file write port between MEM/WB writeback and the
// multi-cycle (mul/div) unit. The pipeline normally has priority. A starvation
// counter hands the port to the MC unit for one cycle after STARVE_LIMIT
// consecutive denials.
// Optional feature: define WB_STALL_COUNT_EN to build a saturating 16-bit
// stall-cycle counter on o_Stall_Count. When it is not defined, the output is
// tied to zero.
//
// state    | meaning
// PIPE_PRI | pipeline wins; MC only gets the port when the pipe does not need it
// MC_PRI   | MC wins if valid; always exits to PIPE_PRI after one cycle
module wb_port_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                      i_Clk,
    input  logic                      i_Reset_n,
    input  logic                      i_Pipe_Writes_Back,
    input  logic [REG_ADDR_WIDTH-1:0] i_Pipe_Write_Addr,
    input  logic [DATA_WIDTH-1:0]     i_Pipe_Data,
    output logic                      o_Pipe_Stall,
    input  logic                      i_Mc_Valid,
    input  logic [REG_ADDR_WIDTH-1:0] i_Mc_Addr,
    input  logic [DATA_WIDTH-1:0]     i_Mc_Data,
    output logic                      o_Mc_Ready,
    output logic                      o_RF_Write_En,
    output logic [REG_ADDR_WIDTH-1:0] o_RF_Write_Addr,
    output logic [DATA_WIDTH-1:0]     o_RF_Write_Data,
    output logic [15:0]               o_Stall_Count
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT_M1 = SW'(STARVE_LIMIT - 1);
    localparam logic [SW-1:0] ONE      = SW'(1);

    typedef enum logic {PIPE_PRI, MC_PRI} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            pipe_req;
    logic            mc_grant;
    logic            pipe_grant;

    // Grant decision, next state and starvation counter update
    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        mc_grant   = 1'b0;
        pipe_grant = 1'b0;
        pipe_req   = i_Pipe_Writes_Back && (i_Pipe_Write_Addr != '0);
        case (state_q)
            PIPE_PRI: begin
                pipe_grant = pipe_req;
                mc_grant   = i_Mc_Valid && !pipe_req;
                if (mc_grant) begin
                    starve_d = '0;
                end else if (i_Mc_Valid) begin
                    starve_d = starve_q + ONE;
                    if (starve_q == LIMIT_M1) begin
                        state_d = MC_PRI;
                    end
                end
            end
            MC_PRI: begin
                mc_grant   = i_Mc_Valid;
                pipe_grant = pipe_req && !i_Mc_Valid;
                state_d    = PIPE_PRI;
                starve_d   = '0;
            end
            default: begin
                state_d  = PIPE_PRI;
                starve_d = '0;
            end
        endcase
    end

    // Handshake outputs are forced low while reset is held
    assign o_Mc_Ready   = mc_grant && i_Reset_n;
    assign o_Pipe_Stall = pipe_req && mc_grant && i_Reset_n;

    // State and starvation counter registers
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q  <= PIPE_PRI;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Registered RF write port; an MC result to r0 is consumed without a write
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            o_RF_Write_En   <= 1'b0;
            o_RF_Write_Addr <= '0;
            o_RF_Write_Data <= '0;
        end else if (mc_grant && (i_Mc_Addr != '0)) begin
            o_RF_Write_En   <= 1'b1;
            o_RF_Write_Addr <= i_Mc_Addr;
            o_RF_Write_Data <= i_Mc_Data;
        end else if (pipe_grant) begin
            o_RF_Write_En   <= 1'b1;
            o_RF_Write_Addr <= i_Pipe_Write_Addr;
            o_RF_Write_Data <= i_Pipe_Data;
        end else begin
            o_RF_Write_En   <= 1'b0;
        end
    end

`ifdef WB_STALL_COUNT_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of pipeline stall cycles
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            stall_cnt_q <= '0;
        end else if (o_Pipe_Stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign o_Stall_Count = stall_cnt_q;
`else
    assign o_Stall_Count = 16'd0;
`endif

endmodule
